// File: rtl/vga_draw_pkg.sv
// ============================================================================
// Module   : vga_draw_pkg
// Purpose  : Shared screen geometry, pixel field widths and arbiter state codes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pixel_t;

  function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational round-robin winner search with optional fixed
//            top priority for requester 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_prio0,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_pos    = 0;
    if (i_prio0 && i_req[0]) begin
      o_valid = 1'b1;
    end else begin
      // First set bit at or after i_ptr, wrapping past N-1 back to 0
      for (int k = 0; k < N; k++) begin
        if (!o_valid) begin
          w_pos = (int'(i_ptr) + k) % N;
          if (i_req[IDX_W'(w_pos)]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(w_pos);
          end
        end
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
// ============================================================================
// Module   : vga_draw_arbiter
// Purpose  : Grants the single VGA pixel-write port to one drawing engine per
//            burst, registers its pixels and drops off-screen writes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PRIO0        = 1,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     last,
  input  logic [X_W*NUM_REQ-1:0] xin,
  input  logic [Y_W*NUM_REQ-1:0] yin,
  input  logic [C_W*NUM_REQ-1:0] colourIn,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [X_W-1:0]         xout,
  output logic [Y_W-1:0]         yout,
  output logic [C_W-1:0]         colourOut,
  output logic                   drawEn,
  output logic                   clipped,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_idle;
  pixel_t             r_pix;
  logic               r_draw;
  logic               r_clip;

  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_valid;

  pixel_t             w_pix_arr [NUM_REQ];
  pixel_t             w_own_pix;
  logic               w_own_req;
  logic               w_own_last;
  logic               w_accept;
  logic               w_in_range;
  logic [CNT_W-1:0]   w_idle_next;
  logic               w_timeout;
  logic               w_release;
  logic [PTR_W-1:0]   w_ptr_next;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_pix_arr[i].x = xin[i*X_W +: X_W];
      assign w_pix_arr[i].y = yin[i*Y_W +: Y_W];
      assign w_pix_arr[i].c = colourIn[i*C_W +: C_W];
    end
  endgenerate

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_prio0  (PRIO0 != 0),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_own_pix   = w_pix_arr[r_owner];
  assign w_own_req   = req[r_owner];
  assign w_own_last  = last[r_owner];
  assign w_accept    = (r_state == ST_GRANT) && w_own_req;
  assign w_in_range  = in_screen(w_own_pix.x, w_own_pix.y);
  assign w_idle_next = r_idle + 1'b1;
  // The idle cycle that brings the count to IDLE_TIMEOUT is itself the release cycle
  assign w_timeout   = (r_state == ST_GRANT) && !w_own_req &&
                       (w_idle_next == CNT_W'(IDLE_TIMEOUT));
  assign w_release   = (w_accept && w_own_last) || w_timeout;
  assign w_ptr_next  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_idle  <= '0;
      r_pix   <= '0;
      r_draw  <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_draw <= 1'b0;
      r_clip <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_pick_valid) begin
          r_state <= ST_GRANT;
          r_gnt   <= w_pick_onehot;
          r_owner <= w_pick_idx;
          r_idle  <= '0;
        end
      end else begin
        if (w_accept) begin
          r_idle <= '0;
          if (w_in_range) begin
            r_pix  <= w_own_pix;
            r_draw <= 1'b1;
          end else begin
            r_clip <= 1'b1;
          end
        end else begin
          r_idle <= w_idle_next;
        end
        if (w_release) begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_ptr   <= w_ptr_next;
          r_idle  <= '0;
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign xout      = r_pix.x;
  assign yout      = r_pix.y;
  assign colourOut = r_pix.c;
  assign drawEn    = r_draw;
  assign clipped   = r_clip;
  assign busy      = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
// ============================================================================
// Module   : tb_vga_draw_arbiter
// Purpose  : Scoreboard bench for vga_draw_arbiter with directed scenarios and
//            randomized engine traffic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_draw_arbiter;
  import vga_draw_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam bit P0 = 1'b1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [8*N-1:0] xin = '0;
  logic [7*N-1:0] yin = '0;
  logic [3*N-1:0] colourIn = '0;
  logic [N-1:0]   gnt;
  logic [7:0]     xout;
  logic [6:0]     yout;
  logic [2:0]     colourOut;
  logic           drawEn, clipped, busy;

  vga_draw_arbiter #(.NUM_REQ(N), .PRIO0(1), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .xin(xin), .yin(yin),
    .colourIn(colourIn), .gnt(gnt), .xout(xout), .yout(yout),
    .colourOut(colourOut), .drawEn(drawEn), .clipped(clipped), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c; bit last;} px_t;
  typedef struct {logic [N-1:0] gnt; bit draw; bit clip; logic [7:0] x; logic [6:0] y; logic [2:0] c;} cyc_t;

  px_t  eng_q [N][$];
  int   eng_stall [N];
  cyc_t exp_q [$];
  px_t  wr_q [$];
  int   gnt_log [$];
  int   n_vec = 0, n_err = 0;
  int   draw_seen = 0, clip_seen = 0;
  bit   rnd_en = 1'b0;

  // Reference model: who owns the port, where the rotation resumes, idle run length
  int         m_owner = -1, m_ptr = 0, m_idle = 0;
  logic [7:0] m_x = '0;
  logic [6:0] m_y = '0;
  logic [2:0] m_c = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    if (P0 && r[0]) return 0;
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic push_px(input int i, input int x, input int y, input int c, input bit l);
    px_t p;
    p.x = 8'(x); p.y = 7'(y); p.c = 3'(c); p.last = l;
    eng_q[i].push_back(p);
  endtask

  task automatic new_burst(input int i);
    int len;
    len = $urandom_range(1, 8);
    for (int k = 0; k < len; k++)
      push_px(i, ($urandom_range(0, 4) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119),
                 $urandom_range(0, 7), k == len - 1);
  endtask

  // Drive one cycle of engine traffic, advance the model, queue the expected outputs
  task automatic tick();
    logic [N-1:0] r, l;
    px_t  p;
    cyc_t e;
    int   o;
    for (int i = 0; i < N; i++) begin
      if (rnd_en) begin
        if (eng_q[i].size() == 0 && $urandom_range(0, 7) == 0) new_burst(i);
        if (eng_stall[i] == 0 && $urandom_range(0, 39) == 0) eng_stall[i] = $urandom_range(1, 24);
      end
      r[i] = (eng_q[i].size() != 0) && (eng_stall[i] == 0);
      if (eng_q[i].size() != 0) begin
        p = eng_q[i][0];
        xin[8*i +: 8] = p.x; yin[7*i +: 7] = p.y; colourIn[3*i +: 3] = p.c; l[i] = p.last;
      end else begin
        xin[8*i +: 8] = 8'($urandom); yin[7*i +: 7] = 7'($urandom);
        colourIn[3*i +: 3] = 3'($urandom); l[i] = 1'($urandom);
      end
      if (eng_stall[i] > 0) eng_stall[i]--;
    end
    req = r; last = l;

    e.draw = 1'b0; e.clip = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) m_owner = pick(r);
    end else begin
      o = m_owner;
      if (r[o]) begin
        p = eng_q[o].pop_front();
        if (int'(p.x) < SCREEN_W && int'(p.y) < SCREEN_H) begin
          e.draw = 1'b1; m_x = p.x; m_y = p.y; m_c = p.c;
          wr_q.push_back(p);
        end else begin
          e.clip = 1'b1;
        end
        m_idle = 0;
        if (p.last) begin m_owner = -1; m_ptr = (o + 1) % N; end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_owner = -1; m_ptr = (o + 1) % N; m_idle = 0; end
      end
    end
    e.gnt = '0;
    if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
    e.x = m_x; e.y = m_y; e.c = m_c;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string name, input int bound);
    bit done;
    done = 1'b0;
    for (int n = 0; n < bound; n++) begin
      done = (m_owner < 0);
      for (int i = 0; i < N; i++) if (eng_q[i].size() != 0) done = 1'b0;
      if (done) break;
      tick();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s: not idle after %0d cycles, required idle", name, bound);
    end
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drawEn", 32'(drawEn), 0);
    check("rst_clipped", 32'(clipped), 0);
    check("rst_xout", 32'(xout), 0);
    exp_q.delete(); wr_q.delete();
    for (int i = 0; i < N; i++) begin eng_q[i].delete(); eng_stall[i] = 0; end
    req = '0;
    m_owner = -1; m_ptr = 0; m_idle = 0; m_x = '0; m_y = '0; m_c = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle
  initial begin
    cyc_t e;
    px_t  w;
    logic [N-1:0] prev = '0;
    forever begin
      @(posedge clk); #1;
      if (drawEn === 1'b1) draw_seen++;
      if (clipped === 1'b1) clip_seen++;
      if (gnt != prev && gnt != '0)
        for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
      prev = gnt;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("busy", 32'(busy), 32'(e.gnt != '0));
        check("drawEn", 32'(drawEn), 32'(e.draw));
        check("clipped", 32'(clipped), 32'(e.clip));
        check("xout", 32'(xout), 32'(e.x));
        check("yout", 32'(yout), 32'(e.y));
        check("colourOut", 32'(colourOut), 32'(e.c));
        if (drawEn === 1'b1) begin
          if (wr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL write: drawEn=1 with x=%0d y=%0d, expected no write", xout, yout);
          end else begin
            w = wr_q.pop_front();
            check("wr_xy", {17'd0, xout, yout}, {17'd0, w.x, w.y});
          end
        end
      end
    end
  end

  initial begin
    int d0, c0;
    for (int i = 0; i < N; i++) eng_stall[i] = 0;
    repeat (2) @(negedge clk);
    check("init_gnt", 32'(gnt), 0);
    check("init_busy", 32'(busy), 0);
    check("init_drawEn", 32'(drawEn), 0);
    check("init_clipped", 32'(clipped), 0);
    check("init_pix", {14'd0, xout, yout, colourOut}, 0);
    reset = 1'b0;

    // Round-robin among 1..3, two 3-pixel bursts each
    gnt_log.delete();
    for (int b = 0; b < 2; b++)
      for (int i = 1; i < N; i++)
        for (int k = 0; k < 3; k++) push_px(i, 10 * i + k, i + b, i, k == 2);
    run_until_idle("rr_drain", 200);
    tick();
    check("rr_g0", 32'(gnt_log[0]), 1);
    check("rr_g1", 32'(gnt_log[1]), 2);
    check("rr_g2", 32'(gnt_log[2]), 3);
    check("rr_g3", 32'(gnt_log[3]), 1);

    // 11x10 sprite on requester 1
    d0 = draw_seen; c0 = clip_seen;
    for (int k = 0; k < 110; k++) push_px(1, 73 + k % 11, 105 + k / 11, k % 8, k == 109);
    run_until_idle("sprite_drain", 400);
    tick();
    check("sprite_draws", 32'(draw_seen - d0), 110);
    check("sprite_clips", 32'(clip_seen - c0), 0);

    // Requester 0 arrives mid-burst of 2 while 3 waits
    gnt_log.delete();
    for (int k = 0; k < 6; k++) push_px(2, 20 + k, 30, 2, k == 5);
    for (int k = 0; k < 2; k++) push_px(3, 40 + k, 31, 3, k == 1);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) push_px(0, 60 + k, 32, 5, k == 2);
    run_until_idle("prio_drain", 200);
    tick();
    check("prio_g0", 32'(gnt_log[0]), 2);
    check("prio_g1", 32'(gnt_log[1]), 0);
    check("prio_g2", 32'(gnt_log[2]), 3);

    // Right-edge clipping
    d0 = draw_seen; c0 = clip_seen;
    push_px(1, 158, 50, 1, 0); push_px(1, 159, 50, 2, 0);
    push_px(1, 160, 50, 3, 0); push_px(1, 163, 50, 4, 1);
    run_until_idle("clip_drain", 100);
    tick();
    check("clip_draws", 32'(draw_seen - d0), 2);
    check("clip_pulses", 32'(clip_seen - c0), 2);

    // Owner goes quiet after 5 pixels, no last
    gnt_log.delete();
    for (int k = 0; k < 5; k++) push_px(1, 100 + k, 60, 6, 0);
    repeat (2) tick();
    push_px(2, 5, 5, 7, 0); push_px(2, 6, 5, 7, 1);
    run_until_idle("timeout_drain", 100);
    tick();
    check("to_g0", 32'(gnt_log[0]), 1);
    check("to_g1", 32'(gnt_log[1]), 2);

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 8; k++) push_px(2, 80 + k, 70, 1, k == 7);
    repeat (4) tick();
    mid_reset();
    gnt_log.delete();
    push_px(1, 1, 1, 1, 1); push_px(3, 3, 3, 3, 1);
    run_until_idle("post_rst_drain", 100);
    tick();
    check("post_rst_g0", 32'(gnt_log[0]), 1);

    // Randomized traffic from all engines
    rnd_en = 1'b1;
    repeat (3000) tick();
    rnd_en = 1'b0;
    run_until_idle("random_drain", 2000);
    repeat (2) tick();
    check("wr_q_empty", 32'(wr_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
